uc_dispatch_buffer: RTL and testbench
=====================================

// Module: uc_dispatch_buffer
// PURPOSE
//  Parametrised unit-clause FIFO between the clause arbiter and the BCP engines.
//  Buffers incoming clauses in a circular store. During a run it presents up to
//  NUM_ENGINE head entries per cycle, and pops however many the engines report taken.
//  Adds to the previous latency buffer: configurable depth and widths, full/ready
//  backpressure, flush, occupancy count, sticky overflow/underflow error flags.
// PARAMETERS
//  LIT_IDX_MAX   1024  max literal index; VAR_W = $clog2(LIT_IDX_MAX)+1
//  CLA_LENGTH    3     literals per clause; CLAUSE_W = VAR_W*CLA_LENGTH
//  NUM_ENGINE    4     dispatch window width; CNT_W = $clog2(NUM_ENGINE)+1
//  DEPTH         1024  storage entries, power of 2; PTR_W = $clog2(DEPTH)+1 (wrap bit)
//  INIT_BUBBLES  4     zero clauses present after reset (0..DEPTH), pipeline primers
// PORTS
//  clock               in   1               single clock, rising edge
//  reset               in   1               synchronous, active-high
//  load_sig_in         in   1               push clause_in
//  clause_in           in   CLAUSE_W        clause to push
//  load_ready_out      out  1               push accepted if asserted
//  start_in            in   1               run enable; dispatch while high
//  flush_in            in   1               empty buffer, clear error flags
//  clause_received_in  in   CNT_W           entries consumed this cycle
//  clause_released_out out  CNT_W           entries presented this cycle
//  clause_valid_out    out  NUM_ENGINE      thermometer mask of valid slots
//  clause_out          out  NUM_ENGINE*CLAUSE_W  slot i = entry head+i, 0 if invalid
//  count_out           out  PTR_W           occupancy, 0..DEPTH
//  empty_out/full_out  out  1               count==0 (RUN only) / count==DEPTH
//  start_out           out  1               registered start_in
//  overflow_out        out  1               sticky: push while not ready
//  underflow_out       out  1               sticky: received > released
// BEHAVIOUR
//  - Input stage: load_sig_in, clause_in, start_in, flush_in are registered (1 cycle).
//    A push sampled at edge k is written at edge k+1 and can be dispatched from then.
//  - Reset: head=0, tail=INIT_BUBBLES, entries[0..INIT_BUBBLES-1]=0, state=IDLE,
//    input regs/flags=0. Outputs: released=0, valid=0, clause_out=0, empty=0,
//    full=(INIT_BUBBLES==DEPTH), count=INIT_BUBBLES, start_out=0, ready=(INIT_BUBBLES<DEPTH).
//  - FSM: IDLE -> RUN when start_q=1; RUN -> IDLE when start_q=0; any -> IDLE on flush_q.
//    Dispatch outputs are forced to 0 in IDLE.
//  - Pointers: PTR_W bits, index = low bits, MSB = wrap. empty: head==tail.
//    full: low bits equal, MSB differs. count = tail-head mod 2^PTR_W.
//  - Dispatch (RUN, combinational from regs): released = min(count, NUM_ENGINE).
//    valid[i]=1 for i<released. Slot index wraps mod DEPTH.
//  - Pop: in RUN, head += min(clause_received_in, released) at the edge.
//    If received > released, clamp and set underflow_out. Received is ignored in IDLE.
//  - load_ready_out = (count + load_q) < DEPTH, i.e. it reserves a slot for the
//    staged push. A push sampled with ready=0 is dropped and sets overflow_out.
//  - Same-cycle push and pop are both applied; count changes by push-pop.
//  - flush_q has priority over everything: head=tail=0 (no bubbles), staged push is
//    discarded, flags cleared, state=IDLE.
//  - Reset mid-run returns to the reset state exactly; in-flight data is lost.
// TESTING
//  1 Reset, INIT_BUBBLES=4, start=1 -> 2 cycles later released=4, valid=4'b1111,
//    all slots 0; received=4 -> next cycle count=0, empty=1.
//  2 Push A,B,C on consecutive cycles during RUN, received=0 -> slots 0..2=A,B,C,
//    valid=4'b0111, released=3. A is visible 2 cycles after its push.
//  3 DEPTH=8, INIT_BUBBLES=0: push 8 without pops -> ready falls when count+staged=8,
//    full=1. A 9th push is dropped and overflow_out=1; count stays 8.
//  4 Wrap: DEPTH=8, push/pop 13 entries -> order preserved across index 7->0 and
//    wrap bit toggles. count matches a model every cycle.
//  5 released=2, received=3 -> head +2 only, underflow_out=1 (sticky until flush).
//  6 flush mid-run with count=5 and a push staged -> next cycle count=0, flags 0,
//    state IDLE, valid=0. A push after the flush lands at index 0.

Source files
------------

// File: rtl/uc_dispatch_buffer.sv
// uc_dispatch_buffer: unit-clause FIFO between the clause arbiter and the BCP engines.
// Clauses are pushed through a one-cycle input stage into a circular store. While running,
// up to NUM_ENGINE head entries are presented each cycle, and the engines report how many
// they took; those are popped at the next edge.
// Ports:
//   clock, reset                 rising-edge clock, synchronous active-high reset
//   load_sig_in, clause_in       push request and clause payload
//   load_ready_out               push accepted when high
//   start_in / start_out         run enable / its registered copy
//   flush_in                     empty the buffer and clear the error flags
//   clause_received_in           entries consumed this cycle
//   clause_released_out          entries presented this cycle
//   clause_valid_out             thermometer mask of valid dispatch slots
//   clause_out                   slot i = entry head+i, zero when invalid
//   count_out                    occupancy, 0..DEPTH
//   empty_out, full_out          buffer empty (RUN only) / buffer full
//   overflow_out, underflow_out  sticky error flags
module uc_dispatch_buffer #(
  parameter int unsigned LIT_IDX_MAX  = 1024,
  parameter int unsigned CLA_LENGTH   = 3,
  parameter int unsigned NUM_ENGINE   = 4,
  parameter int unsigned DEPTH        = 1024,
  parameter int unsigned INIT_BUBBLES = 4,
  localparam int unsigned VAR_W    = $clog2(LIT_IDX_MAX) + 1,
  localparam int unsigned CLAUSE_W = VAR_W * CLA_LENGTH,
  localparam int unsigned CNT_W    = $clog2(NUM_ENGINE) + 1,
  localparam int unsigned PTR_W    = $clog2(DEPTH) + 1
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           load_sig_in,
  input  logic [CLAUSE_W-1:0]            clause_in,
  output logic                           load_ready_out,
  input  logic                           start_in,
  input  logic                           flush_in,
  input  logic [CNT_W-1:0]               clause_received_in,
  output logic [CNT_W-1:0]               clause_released_out,
  output logic [NUM_ENGINE-1:0]          clause_valid_out,
  output logic [NUM_ENGINE*CLAUSE_W-1:0] clause_out,
  output logic [PTR_W-1:0]               count_out,
  output logic                           empty_out,
  output logic                           full_out,
  output logic                           start_out,
  output logic                           overflow_out,
  output logic                           underflow_out
);

  localparam int unsigned IDX_W = PTR_W - 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t                state, state_nxt;
  logic                  load_q, start_q, flush_q;
  logic [CLAUSE_W-1:0]   clause_q;
  logic [PTR_W-1:0]      head, tail;
  logic [CLAUSE_W-1:0]   mem [DEPTH];
  logic                  overflow, underflow;

  logic [PTR_W-1:0]      count_c;
  logic [CNT_W-1:0]      released_c;
  logic [CNT_W-1:0]      pop_c;
  logic                  underflow_evt_c;
  logic                  ready_c;
  logic [NUM_ENGINE-1:0] valid_c;
  logic [NUM_ENGINE*CLAUSE_W-1:0] slots_c;

  // Occupancy from wrap-bit pointers
  assign count_c = tail - head;

  // Reserve a slot for the push already sitting in the input stage
  assign ready_c = ({1'b0, count_c} + (PTR_W+1)'(load_q)) < (PTR_W+1)'(DEPTH);

  // Next-state logic
  always_comb begin
    state_nxt = state;
    if (flush_q) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (start_q)  state_nxt = RUN;
        RUN:     if (!start_q) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Dispatch window and pop amount; everything is zero outside RUN
  always_comb begin
    released_c      = '0;
    pop_c           = '0;
    underflow_evt_c = 1'b0;
    valid_c         = '0;
    slots_c         = '0;
    if (state == RUN) begin
      released_c = (count_c >= PTR_W'(NUM_ENGINE)) ? CNT_W'(NUM_ENGINE) : CNT_W'(count_c);
      underflow_evt_c = clause_received_in > released_c;
      pop_c = underflow_evt_c ? released_c : clause_received_in;
      for (int unsigned i = 0; i < NUM_ENGINE; i++) begin
        if (32'(released_c) > i) begin
          valid_c[i] = 1'b1;
          slots_c[i*CLAUSE_W +: CLAUSE_W] = mem[head[IDX_W-1:0] + IDX_W'(i)];
        end
      end
    end
  end

  // Input stage, pointers, storage and sticky flags
  always_ff @(posedge clock) begin
    if (reset) begin
      load_q    <= 1'b0;
      clause_q  <= '0;
      start_q   <= 1'b0;
      flush_q   <= 1'b0;
      state     <= IDLE;
      head      <= '0;
      tail      <= PTR_W'(INIT_BUBBLES);
      overflow  <= 1'b0;
      underflow <= 1'b0;
      // Zero clauses that prime the downstream pipeline
      for (int i = 0; i < int'(INIT_BUBBLES); i++) begin
        mem[IDX_W'(i)] <= '0;
      end
    end else begin
      load_q   <= load_sig_in && ready_c;
      clause_q <= clause_in;
      start_q  <= start_in;
      flush_q  <= flush_in;
      state    <= state_nxt;
      if (flush_q) begin
        // Flush wins: staged push discarded, no bubbles restored
        head      <= '0;
        tail      <= '0;
        overflow  <= 1'b0;
        underflow <= 1'b0;
      end else begin
        head <= head + PTR_W'(pop_c);
        if (load_q) begin
          mem[tail[IDX_W-1:0]] <= clause_q;
          tail <= tail + PTR_W'(1);
        end
        if (load_sig_in && !ready_c) overflow  <= 1'b1;
        if (underflow_evt_c)         underflow <= 1'b1;
      end
    end
  end

  assign load_ready_out      = ready_c;
  assign clause_released_out = released_c;
  assign clause_valid_out    = valid_c;
  assign clause_out          = slots_c;
  assign count_out           = count_c;
  assign empty_out           = (state == RUN) && (head == tail);
  assign full_out            = (head[IDX_W-1:0] == tail[IDX_W-1:0]) &&
                               (head[PTR_W-1] != tail[PTR_W-1]);
  assign start_out           = start_q;
  assign overflow_out        = overflow;
  assign underflow_out       = underflow;

endmodule

// File: tb/tb_uc_dispatch_buffer.sv
// Directed bench for uc_dispatch_buffer: instance a uses default parameters,
// instance b uses DEPTH=8 with no bubbles for the full/wrap/flush scenarios.
module tb_uc_dispatch_buffer;

  localparam int CW = 33;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Instance a (DEPTH=1024, INIT_BUBBLES=4)
  logic           rst_a, ld_a, st_a, fl_a;
  logic [CW-1:0]  cl_a;
  logic [2:0]     rcv_a, rel_a;
  logic           ready_a, emp_a, full_a, so_a, ov_a, un_a;
  logic [3:0]     val_a;
  logic [4*CW-1:0] co_a;
  logic [10:0]    cnt_a;

  // Instance b (DEPTH=8, INIT_BUBBLES=0)
  logic           rst_b, ld_b, st_b, fl_b;
  logic [CW-1:0]  cl_b;
  logic [2:0]     rcv_b, rel_b;
  logic           ready_b, emp_b, full_b, so_b, ov_b, un_b;
  logic [3:0]     val_b;
  logic [4*CW-1:0] co_b;
  logic [3:0]     cnt_b;

  uc_dispatch_buffer dut_a (
    .clock(clk), .reset(rst_a), .load_sig_in(ld_a), .clause_in(cl_a),
    .load_ready_out(ready_a), .start_in(st_a), .flush_in(fl_a),
    .clause_received_in(rcv_a), .clause_released_out(rel_a),
    .clause_valid_out(val_a), .clause_out(co_a), .count_out(cnt_a),
    .empty_out(emp_a), .full_out(full_a), .start_out(so_a),
    .overflow_out(ov_a), .underflow_out(un_a)
  );

  uc_dispatch_buffer #(.DEPTH(8), .INIT_BUBBLES(0)) dut_b (
    .clock(clk), .reset(rst_b), .load_sig_in(ld_b), .clause_in(cl_b),
    .load_ready_out(ready_b), .start_in(st_b), .flush_in(fl_b),
    .clause_received_in(rcv_b), .clause_released_out(rel_b),
    .clause_valid_out(val_b), .clause_out(co_b), .count_out(cnt_b),
    .empty_out(emp_b), .full_out(full_b), .start_out(so_b),
    .overflow_out(ov_b), .underflow_out(un_b)
  );

  // Reference model for instance b while running
  logic [CW-1:0] mq[$];
  bit            m_staged = 1'b0;
  logic [CW-1:0] m_val = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One cycle of instance b in RUN, checked against the queue model
  task automatic b_step(input bit ld, input logic [CW-1:0] v, input logic [2:0] r);
    bit rdy;
    int rel, pop;
    logic [CW-1:0] e;
    ld_b = ld; cl_b = v; rcv_b = r;
    rdy = (mq.size() + (m_staged ? 1 : 0)) < 8;
    chk("b_ready", 64'(ready_b), 64'(rdy));
    tick();
    rel = (mq.size() < 4) ? mq.size() : 4;
    pop = (int'(r) < rel) ? int'(r) : rel;
    repeat (pop) void'(mq.pop_front());
    if (m_staged) mq.push_back(m_val);
    m_staged = ld && rdy;
    m_val = v;
    rel = (mq.size() < 4) ? mq.size() : 4;
    chk("b_count", 64'(cnt_b), 64'(mq.size()));
    chk("b_released", 64'(rel_b), 64'(rel));
    chk("b_valid", 64'(val_b), 64'((1 << rel) - 1));
    for (int i = 0; i < 4; i++) begin
      e = (i < rel) ? mq[i] : '0;
      chk("b_slot", 64'(co_b[i*CW +: CW]), 64'(e));
    end
  endtask

  localparam logic [CW-1:0] CA = 33'h1_2345_6789;
  localparam logic [CW-1:0] CB = 33'h0_ABCD_0001;
  localparam logic [CW-1:0] CC = 33'h1_0000_FFFF;

  initial begin
    int rpat [8];
    rpat = '{1, 1, 2, 0, 1, 1, 1, 2};
    rst_a = 1; ld_a = 0; st_a = 0; fl_a = 0; cl_a = '0; rcv_a = '0;
    rst_b = 1; ld_b = 0; st_b = 0; fl_b = 0; cl_b = '0; rcv_b = '0;
    tick(); tick();

    // Reset state with four bubbles
    chk("a_rst_count", 64'(cnt_a), 64'(4));
    chk("a_rst_ready", 64'(ready_a), 64'(1));
    chk("a_rst_valid", 64'(val_a), 64'(0));
    chk("a_rst_released", 64'(rel_a), 64'(0));
    chk("a_rst_empty", 64'(emp_a), 64'(0));
    chk("a_rst_full", 64'(full_a), 64'(0));
    chk("a_rst_start", 64'(so_a), 64'(0));
    chk("a_rst_clause0", 64'(co_a != '0), 64'(0));

    // Start: registered, RUN one cycle later, bubbles dispatched
    rst_a = 0; st_a = 1;
    tick();
    chk("a_start_out", 64'(so_a), 64'(1));
    chk("a_idle_valid", 64'(val_a), 64'(0));
    tick();
    chk("a_run_released", 64'(rel_a), 64'(4));
    chk("a_run_valid", 64'(val_a), 64'(4'hF));
    chk("a_bubbles_zero", 64'(co_a != '0), 64'(0));
    chk("a_run_empty", 64'(emp_a), 64'(0));
    rcv_a = 4;
    tick();
    rcv_a = 0;
    chk("a_drain_count", 64'(cnt_a), 64'(0));
    chk("a_drain_empty", 64'(emp_a), 64'(1));
    chk("a_drain_valid", 64'(val_a), 64'(0));
    chk("a_drain_unf", 64'(un_a), 64'(0));

    // Push A,B,C; A visible two cycles after its push
    ld_a = 1; cl_a = CA;
    tick();
    chk("a_staged_count", 64'(cnt_a), 64'(0));
    cl_a = CB;
    tick();
    chk("a_A_valid", 64'(val_a), 64'(1));
    chk("a_A_slot0", 64'(co_a[0 +: CW]), 64'(CA));
    cl_a = CC;
    tick();
    ld_a = 0;
    tick();
    chk("a_abc_released", 64'(rel_a), 64'(3));
    chk("a_abc_valid", 64'(val_a), 64'(4'h7));
    chk("a_abc_slot0", 64'(co_a[0*CW +: CW]), 64'(CA));
    chk("a_abc_slot1", 64'(co_a[1*CW +: CW]), 64'(CB));
    chk("a_abc_slot2", 64'(co_a[2*CW +: CW]), 64'(CC));
    chk("a_abc_slot3", 64'(co_a[3*CW +: CW]), 64'(0));
    chk("a_abc_count", 64'(cnt_a), 64'(3));

    // Underflow: released=2, received=3 pops 2 and sets a sticky flag
    rcv_a = 1;
    tick();
    chk("a_pop1_count", 64'(cnt_a), 64'(2));
    chk("a_pop1_slot0", 64'(co_a[0 +: CW]), 64'(CB));
    chk("a_pop1_released", 64'(rel_a), 64'(2));
    rcv_a = 3;
    tick();
    rcv_a = 0;
    chk("a_unf_count", 64'(cnt_a), 64'(0));
    chk("a_unf_flag", 64'(un_a), 64'(1));
    tick();
    chk("a_unf_sticky", 64'(un_a), 64'(1));

    // Reset mid-run restores the reset state
    rst_a = 1;
    tick();
    rst_a = 0;
    chk("a_rerst_count", 64'(cnt_a), 64'(4));
    chk("a_rerst_unf", 64'(un_a), 64'(0));
    chk("a_rerst_valid", 64'(val_a), 64'(0));
    chk("a_rerst_start", 64'(so_a), 64'(0));

    // Fill DEPTH=8 while idle (received ignored), then overflow
    rst_b = 0; rcv_b = 4; ld_b = 1;
    for (int k = 1; k <= 9; k++) begin
      cl_b = CW'(32'h10 + k);
      chk("b_fill_ready", 64'(ready_b), 64'(k <= 8));
      chk("b_fill_count", 64'(cnt_b), 64'((k > 2) ? k - 2 : 0));
      tick();
    end
    ld_b = 0; rcv_b = 0;
    chk("b_full_count", 64'(cnt_b), 64'(8));
    chk("b_full_flag", 64'(full_b), 64'(1));
    chk("b_ovf_flag", 64'(ov_b), 64'(1));
    chk("b_full_ready", 64'(ready_b), 64'(0));
    chk("b_idle_unf", 64'(un_b), 64'(0));
    tick();
    chk("b_full_hold", 64'(cnt_b), 64'(8));
    for (int k = 1; k <= 8; k++) mq.push_back(CW'(32'h10 + k));

    // Run with concurrent push/pop across the index wrap
    st_b = 1;
    tick(); tick();
    chk("b_run_slot0", 64'(co_b[0 +: CW]), 64'(33'h11));
    chk("b_run_released", 64'(rel_b), 64'(4));
    for (int j = 0; j < 24; j++) b_step(1'b1, CW'(32'h100 + j), 3'(rpat[j % 8]));
    for (int j = 0; j < 6; j++) b_step(1'b0, '0, 3'd4);
    chk("b_drained", 64'(cnt_b), 64'(0));
    chk("b_drain_unf", 64'(un_b), 64'(1));

    // Flush with five entries held and a push staged
    for (int j = 0; j < 5; j++) b_step(1'b1, CW'(32'h200 + j), 3'd0);
    ld_b = 1; cl_b = 33'h205; fl_b = 1;
    tick();
    ld_b = 0; fl_b = 0;
    chk("b_preflush_count", 64'(cnt_b), 64'(5));
    tick();
    chk("b_flush_count", 64'(cnt_b), 64'(0));
    chk("b_flush_ovf", 64'(ov_b), 64'(0));
    chk("b_flush_unf", 64'(un_b), 64'(0));
    chk("b_flush_valid", 64'(val_b), 64'(0));
    chk("b_flush_released", 64'(rel_b), 64'(0));
    chk("b_flush_empty", 64'(emp_b), 64'(0));
    chk("b_flush_ready", 64'(ready_b), 64'(1));
    ld_b = 1; cl_b = 33'h1_5A5A_5A5A;
    tick();
    ld_b = 0;
    tick();
    chk("b_post_count", 64'(cnt_b), 64'(1));
    chk("b_post_valid", 64'(val_b), 64'(1));
    chk("b_post_slot0", 64'(co_b[0 +: CW]), 64'(33'h1_5A5A_5A5A));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
